// File: rtl/prv32_div_seq_pkg.sv
// prv32_div_seq_pkg: shared encodings for the prv32 execute stage.
// Holds the ALU operation codes, the divide op codes (funct3[1:0] of the
// M-extension divide group), the divide sequencer state codes, and a
// small helper for conditional two's-complement negation.
package prv32_div_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } alu_op_e;

  // Bit 0 set = unsigned, bit 1 set = remainder.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIVSEQ_IDLE = 2'b00,
    DIVSEQ_RUN  = 2'b01,
    DIVSEQ_FIX  = 2'b10,
    DIVSEQ_DONE = 2'b11
  } divseq_state_e;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;

  function automatic logic [DIV_XLEN-1:0] cond_neg(input logic neg,
                                                   input logic [DIV_XLEN-1:0] val);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/prv32_div_step.sv
// prv32_div_step: one restoring radix-2 division iteration (combinational).
// Ports:
//   rem      - current partial remainder (always < divisor)
//   quo      - current dividend/quotient shift register
//   divisor  - divisor magnitude
//   rem_next - partial remainder after shift/subtract/restore
//   quo_next - quo shifted left with the new quotient bit in bit 0
module prv32_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor};
    // rem < divisor, so rem_sh < 2*divisor: the top bit of diff is a
    // clean borrow flag and a kept difference always fits in XLEN bits.
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/prv32_div_seq.sv
// prv32_div_seq: multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start, op, a, b - request, operation, dividend, divisor (sampled in IDLE)
//   kill           - flush; abandons the operation in flight
//   busy           - state != IDLE, used as the pipeline stall
//   done           - one-cycle result-valid pulse
//   result         - quotient/remainder, held until the next done
//
// state | meaning
// IDLE  | waiting for start; divide-by-zero and overflow resolve here
// RUN   | one restoring step per cycle, 32 steps, counter counts down
// FIX   | sign correction, quotient/remainder select into quo_q
// DONE  | done pulse, result presented and captured
module prv32_div_seq
  import prv32_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  divseq_state_e        state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]      result_q, result_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic            signed_op, sa, sb;

  prv32_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  assign busy = (state_q != DIVSEQ_IDLE);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done      = 1'b0;
    result    = result_q;
    signed_op = ~op[0];
    sa        = signed_op & a[XLEN-1];
    sb        = signed_op & b[XLEN-1];

    case (state_q)
      DIVSEQ_IDLE: begin
        if (start && !kill) begin
          op_d  = op;
          rem_d = '0;
          if (b == '0) begin
            // Quotient all ones, remainder is the dividend untouched.
            quo_d   = op[1] ? a : '1;
            state_d = DIVSEQ_DONE;
          end else if (signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
            quo_d   = op[1] ? '0 : a;
            state_d = DIVSEQ_DONE;
          end else begin
            quo_d     = cond_neg(sa, a);
            dvs_d     = cond_neg(sb, b);
            neg_quo_d = sa ^ sb;
            neg_rem_d = sa;
            cnt_d     = DIV_CNT_W'(XLEN);
            state_d   = DIVSEQ_RUN;
          end
        end
      end
      DIVSEQ_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = DIVSEQ_FIX;
      end
      DIVSEQ_FIX: begin
        // quo_q becomes the output staging register from here on.
        quo_d   = op_q[1] ? cond_neg(neg_rem_q, rem_q) : cond_neg(neg_quo_q, quo_q);
        state_d = DIVSEQ_DONE;
      end
      DIVSEQ_DONE: begin
        done     = 1'b1;
        result   = quo_q;
        result_d = quo_q;
        state_d  = DIVSEQ_IDLE;
      end
      default: state_d = DIVSEQ_IDLE;
    endcase

    if (kill) begin
      state_d  = DIVSEQ_IDLE;
      done     = 1'b0;
      result   = result_q;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIVSEQ_IDLE;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_prv32_div_seq.sv
// tb_prv32_div_seq: directed plus randomised checks of prv32_div_seq.
module tb_prv32_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  prv32_div_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics, independent of the RTL algorithm.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return sx / sy;
      2'b01:   return x / y;
      2'b10:   return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Caller is positioned between edges; start is sampled at the next posedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    op = o; a = x; b = y; start = 1'b1;
    e.res = exp_res;
    e.lat = exp_lat;
    sb_q.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    e = sb_q.pop_front();
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, lat, e.lat);
    check({tag, " result"}, result, e.res);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " result_hold"}, result, e.res);
  endtask

  initial begin
    int          lat;
    int          extra;
    bit          seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_no_ovf");
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2");

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb), "random");
    end

    // kill during RUN at cycle N+10, then a fresh operation
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill_run done", 32'(done), 32'd0);
    check("kill_run busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("kill_run busy_after", 32'(busy), 32'd0);
    run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "after_kill");

    // kill together with start in IDLE
    op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill_start busy", 32'(busy), 32'd0);

    // start while busy is ignored
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3; end
      if (lat == 6) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check("busy_start latency", lat, 34);
    check("busy_start result", result, 32'd14);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("busy_start no_queue", extra, 0);

    // kill in DONE: no pulse, result keeps previous value (14)
    op = 2'b00; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (33) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill_done done", 32'(done), 32'd0);
    check("kill_done result", result, 32'd14);
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("kill_done busy", 32'(busy), 32'd0);
    check("kill_done result_after", result, 32'd14);

    // reset mid-operation at N+20, with a second start under reset
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    extra = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrst no_done", extra, 0);
    check("midrst result_after", result, 32'd0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 34, "after_reset");

    check("scoreboard empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prv32_div_seq.md
PRV32_DIV_SEQ -- requirements
Module: prv32_div_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; only 32 is supported.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of the M-extension divide group).
REQ-006 a  input  32  dividend; sampled with start.
REQ-007 b  input  32  divisor; sampled with start.
REQ-008 kill  input  1  pipeline flush; abandons any operation in flight.
REQ-009 busy  output  1  high in every state except IDLE; drives the pipeline stall.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  32  quotient or remainder; holds its last value until the next done.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-013 IDLE with start=1 and kill=0 SHALL latch op, a and b; on a normal operation the next state SHALL be RUN.
REQ-014 On entry to RUN, signed ops SHALL work on operand magnitudes; the signs of the quotient (sa^sb) and of the remainder (sa) SHALL be recorded.
REQ-015 RUN SHALL perform one restoring radix-2 step per cycle, exactly 32 steps, with a 6-bit step counter that counts down from 32.
REQ-016 Each step SHALL shift {rem,quo} left by 1 and subtract the divisor from the 33-bit partial remainder; on a non-negative difference it SHALL keep the difference and set quo[0]=1, otherwise it SHALL restore.
REQ-017 When the counter reaches 0 the FSM SHALL go to FIX, which applies two's-complement sign correction and selects quo for ops 0x and rem for ops 1x.
REQ-018 FIX SHALL go to DONE; DONE SHALL assert done, drive result, and return to IDLE on the next cycle.
REQ-019 Normal latency: start sampled at edge N, done high in cycle N+34 (32 RUN + FIX + DONE).
REQ-020 Divide by zero (b=0) SHALL bypass RUN and FIX: IDLE goes directly to DONE, done high in cycle N+1.
REQ-021 On divide by zero, the quotient SHALL be 0xFFFFFFFF for both DIV and DIVU, and the remainder SHALL be a.
REQ-022 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) SHALL bypass to DONE at N+1 with quotient 0x80000000 and remainder 0.
REQ-023 start while busy SHALL be ignored, with no queuing.
REQ-024 kill in any state SHALL force IDLE on the next edge and suppress done.
REQ-025 kill together with start in IDLE SHALL win: no operation is launched.
REQ-026 kill in DONE SHALL suppress done in that cycle; result SHALL be left unchanged.
REQ-027 busy SHALL be combinational from state only (state != IDLE), with no dependence on the current start.

Reset
REQ-028 rst SHALL force, asynchronously, state=IDLE, busy=0, done=0, result=0, counter=0 and all operand/partial registers to 0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; the first start after release SHALL behave as from power-up.

Structure
REQ-030 The op encodings (DIV_OP_*) and the state encodings (DIVSEQ_*) SHALL live in the shared defines file alongside the ALU_* codes.
REQ-031 One combinational sub-module, prv32_div_step, SHALL implement a single shift/subtract/restore iteration: inputs rem, quo, divisor; outputs next rem and next quo.
REQ-032 The top-level SHALL contain only the FSM, the counter, the sign handling and the registers; no "/" or "%" operators anywhere.

Verification
REQ-033 DIVU a=100, b=7 -> done at N+34, result=14; REMU with the same operands -> result=2.
REQ-034 DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-035 DIV a=5, b=0 -> done at N+1, result=0xFFFFFFFF; REMU a=5, b=0 -> result=5.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> done at N+1, result=0x80000000; REM with the same operands -> 0.
REQ-037 Start DIVU, then assert kill at cycle N+10 -> no done, busy=0 at N+11; a new start at N+11 completes normally at N+45.
REQ-038 Start DIVU, pulse rst at N+20, then a second start during busy -> after reset all outputs are 0; the second start is ignored; no done appears for either.
